// File: rtl/m_cp0.sv
// MIPS coprocessor 0 for the M stage: SR, Cause, EPC and PRId registers,
// exception/interrupt request generation, and mtc0/mfc0/eret handling.
module m_cp0 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic        Req
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned IRQW   = 6;
  localparam int unsigned EXCW   = 5;
  localparam logic [4:0]  ADDR_SR    = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE = 5'd13;
  localparam logic [4:0]  ADDR_EPC   = 5'd14;
  localparam logic [4:0]  ADDR_PRID  = 5'd15;
  localparam logic [XLEN-1:0] PRID_VAL = 32'h0000_7000;

  logic [IRQW-1:0] im_q, im_d;
  logic            exl_q, exl_d;
  logic            ie_q, ie_d;
  logic            bd_q, bd_d;
  logic [IRQW-1:0] ip_q, ip_d;
  logic [EXCW-1:0] exc_q, exc_d;
  logic [XLEN-1:0] epc_q, epc_d;

  logic            int_req;
  logic            exc_req;
  logic [XLEN-1:0] epc_victim;
  logic            unused_cp0in;

  assign unused_cp0in = ^{CP0In[31:16], CP0In[9:2]};

  assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_req = (ExcCodeIn != '0) & ~exl_q;
  assign Req     = (int_req | exc_req) & ~reset;
  assign EPCOut  = epc_q;

  // EPC holds restart address minus 4; eret adds 4 back in next-PC logic
  assign epc_victim = BDIn ? (VPC - XLEN'(8)) : (VPC - XLEN'(4));

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = HWInt;
    exc_d = exc_q;
    epc_d = epc_q;
    if (Req) begin
      exl_d = 1'b1;
      bd_d  = BDIn;
      exc_d = int_req ? EXCW'(0) : ExcCodeIn;
      epc_d = epc_victim;
    end else begin
      if (en) begin
        case (CP0Add)
          ADDR_SR: begin
            im_d  = CP0In[15:10];
            exl_d = CP0In[1];
            ie_d  = CP0In[0];
          end
          ADDR_EPC: epc_d = CP0In;
          default: ;
        endcase
      end
      // eret clear overrides a same-cycle mtc0 to the EXL bit
      if (EXLClr) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  // mfc0 read mux
  always_comb begin
    CP0Out = '0;
    case (CP0Add)
      ADDR_SR:    CP0Out = {16'b0, im_q, 8'b0, exl_q, ie_q};
      ADDR_CAUSE: CP0Out = {bd_q, 15'b0, ip_q, 3'b0, exc_q, 2'b0};
      ADDR_EPC:   CP0Out = epc_q;
      ADDR_PRID:  CP0Out = PRID_VAL;
      default:    CP0Out = '0;
    endcase
  end

endmodule
